digitallock_sw_debounce: RTL and testbench
==========================================

# digitallock_sw_debounce

Synchronizes and debounces the 10 slide switches of the digital lock board and drives the stable switch vector into the switch PIO input port. It sits directly upstream of the Avalon switch PIO. Besides the level vector, it reports per-bit rise/fall masks and a single-cycle change strobe, so that lock logic or an edge-capture stage sees only clean transitions.

## Interface
Parameters:
- WIDTH, 10, number of switch bits.
- DEBOUNCE_CYCLES, 500000, consecutive clocks a new level must persist before it is accepted (10 ms at 50 MHz). Legal range is 2 to 2^CNT_W−1.
- CNT_W, 19, width of each per-bit counter.

Ports:
- clk, input, 1, system clock; all logic is on its rising edge.
- reset_n, input, 1, asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- sw_in, input, WIDTH, raw asynchronous switch pins.
- sw_out, output, WIDTH, debounced stable level; connects to PIO in_port.
- sw_rise, output, WIDTH, one-cycle mask of bits that became 1 this cycle.
- sw_fall, output, WIDTH, one-cycle mask of bits that became 0 this cycle.
- sw_changed, output, 1, one-cycle strobe; equals OR of sw_rise and sw_fall.

## Operation
- Synchronizer: a 2-flop chain per bit (sync1, then sync2). Only sync2 feeds the debounce logic.
- Each bit has an independent CNT_W-bit counter and a stable register. Per cycle, per bit:
  - If sync2 equals stable, the counter clears to 0.
  - If sync2 differs from stable and the counter is below DEBOUNCE_CYCLES−1, the counter increments by 1.
  - If sync2 differs from stable and the counter equals DEBOUNCE_CYCLES−1, stable takes the value of sync2 and the counter clears. The matching sw_rise or sw_fall bit is 1 for exactly that cycle.
- There is no wrap-around. The counter never exceeds DEBOUNCE_CYCLES−1, because it either clears or triggers a flip.
- Glitch handling: any single cycle in which sync2 returns to the stable value restarts the count from 0. A partial count is never retained.
- Simultaneous flips: several bits may flip on the same edge. All of them appear in the masks in that cycle, and sw_changed pulses once.
- sw_out equals stable. sw_rise, sw_fall and sw_changed are registered and derived from the flip condition.
- The block is purely level/pulse based. It has no handshake and no backpressure.

## Timing
- Reset values (asynchronous assert, all registers): sync1, sync2, stable, counters, sw_out, sw_rise, sw_fall and sw_changed are all 0.
- Leaving reset: a switch that is already high is accepted after the full debounce latency. It then produces one sw_rise pulse.
- Latency: sw_in is held at a new level, with edge E0 being the first rising edge that samples it. sw_out changes on edge E(DEBOUNCE_CYCLES+1), i.e. the (DEBOUNCE_CYCLES+2)th edge.
- sw_rise, sw_fall and sw_changed assert on that same edge and deassert on the next edge, unless another bit flips there.
- Minimum accepted pulse width is DEBOUNCE_CYCLES clocks at sync2. Anything shorter produces no output activity.
- Reset asserted mid-count: all counts and the stable level are lost. After release, counting restarts from 0.
- The downstream PIO registers sw_out one more cycle. End-to-end readdata latency is therefore DEBOUNCE_CYCLES+3 edges.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and WIDTH=10.
- Reset: sw_in=0x3FF during reset. After release, sw_out stays 0x000 for 5 edges, then becomes 0x3FF on the 6th edge (E5). sw_rise=0x3FF and sw_changed=1 for one cycle.
- Clean press: sw_in bit 3 goes 0→1 and is held. sw_out=0x008 exactly at E5, with sw_rise=0x008 for one cycle. Releasing it gives sw_fall=0x008 at the corresponding E5.
- Bounce: bit 0 is toggled high for 3 cycles, low for 1, then held high. No change occurs during the bounce. sw_out bit 0 rises 6 edges after the final rising sample.
- Simultaneous: bits 9 and 1 rise and bit 4 falls on the same cycle, starting from sw_out=0x010. At the flip edge, sw_rise=0x202, sw_fall=0x010, a single sw_changed pulse, and sw_out=0x202.
- Reset mid-count: bit 5 is held high and reset_n is pulsed low after 3 edges. Outputs are 0 immediately, asynchronously. After release, sw_out=0x020 only at the 6th edge after release.
- Short glitch: bit 7 goes high for exactly 3 synchronized cycles and then returns low. sw_out, sw_rise, sw_fall and sw_changed never change.

Source files
------------

// File: rtl/digitallock_sw_debounce.sv
// Synchronizes and debounces the lock board slide switches, producing a stable
// level vector for the switch PIO plus one-cycle rise/fall masks and a change strobe.
module digitallock_sw_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] flip;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];

    // A count only survives while sync2 keeps disagreeing with the stable level;
    // any agreeing cycle drops it back to zero, so partial counts are never kept.
    always_comb begin
        flip = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    flip[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            stable     <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            sw_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1      <= sw_in;
            sync2      <= sync1;
            stable     <= stable ^ flip;
            sw_rise    <= flip & sync2;
            sw_fall    <= flip & ~sync2;
            sw_changed <= |flip;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign sw_out = stable;

endmodule

// File: tb/tb_digitallock_sw_debounce.sv
// Self-checking bench for digitallock_sw_debounce: directed vector table, hand-written
// corner sequences, and random switch activity checked against a sliding-window model.
module tb_digitallock_sw_debounce;

    localparam int W = 10;
    localparam int D = 4;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_out;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;

    int total = 0;
    int bad   = 0;

    digitallock_sw_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(19)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sw_in(sw_in),
        .sw_out(sw_out),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_changed(sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sync2 is the input sampled two edges ago; a bit accepts a new
    // level once the last D sync2 samples all disagree with its stable level.
    logic [W-1:0] dly_q [$];
    logic [W-1:0] win_q [$];
    logic [W-1:0] m_stable;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic         m_chg;

    typedef struct {
        logic [W-1:0] in;
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } vec_t;

    vec_t tbl [$];

    task automatic model_reset();
        dly_q.delete();
        dly_q.push_back('0);
        dly_q.push_back('0);
        win_q.delete();
        m_stable = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_chg    = 1'b0;
    endtask

    task automatic model_edge(input logic [W-1:0] v);
        logic [W-1:0] s2;
        logic [W-1:0] fl;
        logic         all_diff;
        s2 = dly_q.pop_front();
        dly_q.push_back(v);
        win_q.push_back(s2);
        if (win_q.size() > D) win_q.delete(0);
        fl = '0;
        if (win_q.size() == D) begin
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                foreach (win_q[k]) if (win_q[k][b] == m_stable[b]) all_diff = 1'b0;
                fl[b] = all_diff;
            end
        end
        m_rise   = fl & s2;
        m_fall   = fl & ~s2;
        m_chg    = |fl;
        m_stable = m_stable ^ fl;
    endtask

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one input value across one rising edge, then compare against the model.
    task automatic apply_stimulus(input logic [W-1:0] v);
        sw_in = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        check_output("model sw_out", sw_out, m_stable);
        check_output("model sw_rise", sw_rise, m_rise);
        check_output("model sw_fall", sw_fall, m_fall);
        check_output("model sw_changed", W'(sw_changed), W'(m_chg));
    endtask

    task automatic do_reset(input logic [W-1:0] v);
        sw_in   = v;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_output("reset sw_out", sw_out, '0);
        check_output("reset sw_rise", sw_rise, '0);
        check_output("reset sw_fall", sw_fall, '0);
        check_output("reset sw_changed", W'(sw_changed), '0);
        reset_n = 1'b1;
    endtask

    function automatic void add_vec(input logic [W-1:0] i, input logic [W-1:0] o,
                                    input logic [W-1:0] r, input logic [W-1:0] f, input logic c);
        vec_t x;
        x.in = i; x.out = o; x.rise = r; x.fall = f; x.chg = c;
        tbl.push_back(x);
    endfunction

    initial begin
        #200us;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] v;

        // Clean press of bit 3 then release, starting from a quiet reset.
        for (int e = 0; e < 7; e++)
            add_vec(10'h008, (e >= 5) ? 10'h008 : 10'h000, (e == 5) ? 10'h008 : 10'h000, 10'h000, e == 5);
        for (int e = 0; e < 7; e++)
            add_vec(10'h000, (e >= 5) ? 10'h000 : 10'h008, 10'h000, (e == 5) ? 10'h008 : 10'h000, e == 5);

        // Switches already high while in reset.
        do_reset(10'h3FF);
        for (int e = 0; e < 7; e++) begin
            apply_stimulus(10'h3FF);
            check_output("rst-high sw_out", sw_out, (e >= 5) ? 10'h3FF : 10'h000);
            check_output("rst-high sw_rise", sw_rise, (e == 5) ? 10'h3FF : 10'h000);
            check_output("rst-high sw_changed", W'(sw_changed), W'(e == 5));
        end

        do_reset(10'h000);
        foreach (tbl[n]) begin
            apply_stimulus(tbl[n].in);
            check_output($sformatf("vec%0d sw_out", n), sw_out, tbl[n].out);
            check_output($sformatf("vec%0d sw_rise", n), sw_rise, tbl[n].rise);
            check_output($sformatf("vec%0d sw_fall", n), sw_fall, tbl[n].fall);
            check_output($sformatf("vec%0d sw_changed", n), W'(sw_changed), W'(tbl[n].chg));
        end

        // Bounce on bit 0: 3 high, 1 low, then held high.
        for (int e = 0; e < 4; e++) begin
            apply_stimulus((e == 3) ? 10'h000 : 10'h001);
            check_output("bounce quiet sw_out", sw_out, 10'h000);
        end
        for (int e = 0; e < 7; e++) begin
            apply_stimulus(10'h001);
            check_output("bounce sw_out", sw_out, (e >= 5) ? 10'h001 : 10'h000);
            check_output("bounce sw_rise", sw_rise, (e == 5) ? 10'h001 : 10'h000);
        end

        // Simultaneous flips: reach 0x010, then bits 9,1 rise and bit 4 falls together.
        for (int e = 0; e < 7; e++) apply_stimulus(10'h010);
        check_output("simul start sw_out", sw_out, 10'h010);
        for (int e = 0; e < 7; e++) begin
            apply_stimulus(10'h202);
            if (e == 5) begin
                check_output("simul sw_rise", sw_rise, 10'h202);
                check_output("simul sw_fall", sw_fall, 10'h010);
                check_output("simul sw_changed", W'(sw_changed), 10'h001);
                check_output("simul sw_out", sw_out, 10'h202);
            end else if (e == 6) begin
                check_output("simul strobe end", W'(sw_changed), 10'h000);
            end
        end

        // Reset asserted mid-count clears outputs asynchronously.
        for (int e = 0; e < 3; e++) apply_stimulus(10'h020);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async rst sw_out", sw_out, 10'h000);
        check_output("async rst sw_changed", W'(sw_changed), 10'h000);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 0; e < 7; e++) begin
            apply_stimulus(10'h020);
            check_output("post-rst sw_out", sw_out, (e >= 5) ? 10'h020 : 10'h000);
        end

        // Glitch on bit 7 shorter than the debounce window.
        for (int e = 0; e < 11; e++) begin
            apply_stimulus((e < 3) ? 10'h0A0 : 10'h020);
            check_output("glitch sw_out", sw_out, 10'h020);
            check_output("glitch sw_changed", W'(sw_changed), 10'h000);
        end

        // Random switch activity; each bit toggles with probability 1/8 per cycle.
        v = 10'h020;
        for (int n = 0; n < 400; n++) begin
            v = v ^ W'($urandom & $urandom & $urandom);
            apply_stimulus(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
